// File: rtl/noc_credit_tx.sv
// noc_credit_tx: transmit side of a credit-based 16-bit NoC link.
// Local flits are buffered in a small circular FIFO. One flit is launched per cycle
// while the queue is non-empty and credits remain. Each credit pulse returns one credit.
// Optional feature macro: NOC_TX_CREDIT_CHECK_EN adds a sticky credit-overflow flag.
// When the macro is undefined, credit_err is tied low.

module noc_credit_tx #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    output logic                     in_ready,
    output logic                     enable,
    output logic [15:0]              data,
    input  logic                     credit,
    output logic [3:0]               credit_cnt,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic                     credit_err
);

    localparam int unsigned AW = $clog2(QDEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t       QFull      = ptr_t'(QDEPTH);
    localparam logic [3:0] CreditsMax = 4'(CREDITS);

    // Queue storage and pointers; pointers carry one wrap bit above the index.
    logic [15:0] mem_q [QDEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;

    logic [3:0]  credit_cnt_q, credit_cnt_d;
    logic        enable_q, enable_d;
    logic [15:0] data_q, data_d;

    logic        push;
    logic        send;
    logic [15:0] head;
    logic [4:0]  credit_sum;

    // Occupancy, handshake and launch decision from registered state only.
    always_comb begin
        q_count  = wr_ptr_q - rd_ptr_q;
        in_ready = (q_count != QFull);
        push     = in_valid && in_ready;
        send     = (q_count != '0) && (credit_cnt_q != 4'd0);
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers, link outputs and the saturating credit counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        enable_d = 1'b0;
        data_d   = data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (send) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
            enable_d = 1'b1;
            data_d   = head;
        end

        // send implies a non-zero count, so the subtraction cannot underflow.
        credit_sum   = {1'b0, credit_cnt_q} + {4'd0, credit} - {4'd0, send};
        credit_cnt_d = (credit_sum > {1'b0, CreditsMax}) ? CreditsMax : credit_sum[3:0];
    end

    // Queue payload write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            credit_cnt_q <= CreditsMax;
            enable_q     <= 1'b0;
            data_q       <= 16'h0000;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            enable_q     <= enable_d;
            data_q       <= data_d;
        end
    end

    assign enable     = enable_q;
    assign data       = data_q;
    assign credit_cnt = credit_cnt_q;

`ifdef NOC_TX_CREDIT_CHECK_EN
    logic credit_err_q;
    logic credit_ovf;

    // A credit while already full and not spending one is an overflow.
    assign credit_ovf = credit && !send && (credit_cnt_q == CreditsMax);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_q <= 1'b0;
        end else if (credit_ovf) begin
            credit_err_q <= 1'b1;
        end
    end

    assign credit_err = credit_err_q;
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_tx.sv
// Self-checking bench for noc_credit_tx: directed scenarios followed by a random phase,
// all compared against a flit-queue / credit-integer reference model.

module tb_noc_credit_tx;

    localparam int unsigned CREDITS = 4;
    localparam int unsigned QDEPTH  = 4;
`ifdef NOC_TX_CREDIT_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        enable;
    logic [15:0] data;
    logic        credit = 1'b0;
    logic [3:0]  credit_cnt;
    logic [2:0]  q_count;
    logic        credit_err;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model state.
    logic [15:0] mq[$];
    int          mcr  = CREDITS;
    bit          men  = 1'b0;
    logic [15:0] mdat = 16'h0000;
    bit          merr = 1'b0;
    bit          macc = 1'b0;

    noc_credit_tx #(
        .CREDITS (CREDITS),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .enable     (enable),
        .data       (data),
        .credit     (credit),
        .credit_cnt (credit_cnt),
        .q_count    (q_count),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the link transmitter, described as queue/credit bookkeeping.
    task automatic model_edge(input bit v, input logic [15:0] d, input bit c, input bit r);
        bit s;
        bit ovf;
        int sum;
        macc = 1'b0;
        if (r) begin
            mq.delete();
            mcr  = CREDITS;
            men  = 1'b0;
            mdat = 16'h0000;
            merr = 1'b0;
        end else begin
            s    = (mq.size() != 0) && (mcr != 0);
            macc = v && (mq.size() < QDEPTH);
            men  = s;
            if (s) mdat = mq.pop_front();
            if (macc) mq.push_back(d);
            ovf = c && !s && (mcr == CREDITS);
            sum = mcr + int'(c) - int'(s);
            mcr = (sum > CREDITS) ? CREDITS : sum;
            if (ErrEn && ovf) merr = 1'b1;
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit c, input bit r);
        in_valid = v;
        in_data  = d;
        credit   = c;
        rst      = r;
        @(posedge clk);
        model_edge(v, d, c, r);
        #1;
        if (enable) pulses++;
        chk("enable", 32'(enable), 32'(men));
        chk("data", 32'(data), 32'(mdat));
        chk("credit_cnt", 32'(credit_cnt), 32'(mcr));
        chk("q_count", 32'(q_count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < QDEPTH));
        chk("credit_err", 32'(credit_err), 32'(merr));
    endtask

    initial begin
        int pushed;
        int given;
        int outstanding;
        bit done;
        bit v;
        bit c;

        // Reset held two cycles with credit and in_valid asserted.
        step(1'b1, 16'hABCD, 1'b1, 1'b1);
        step(1'b1, 16'hABCD, 1'b1, 1'b1);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_credit_cnt", 32'(credit_cnt), 32'd4);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Credit exhaustion: six flits, no credits back.
        pulses = 0;
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("exhaust_pulses", 32'(pulses), 32'd4);
        chk("exhaust_credit_cnt", 32'(credit_cnt), 32'd0);
        chk("exhaust_q_count", 32'(q_count), 32'd2);
        chk("exhaust_last_data", 32'(data), 32'h0004);

        // Credit return latency.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ret_credit_cnt_t1", 32'(credit_cnt), 32'd1);
        chk("ret_enable_t1", 32'(enable), 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("ret_enable_t2", 32'(enable), 32'd1);
        chk("ret_data_t2", 32'(data), 32'h0005);
        chk("ret_credit_cnt_t2", 32'(credit_cnt), 32'd0);

        // Credit pulse coinciding with a send.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("simul_credit_cnt", 32'(credit_cnt), 32'd1);
        chk("simul_data", 32'(data), 32'h0006);

        // Push and pop together with two flits queued.
        step(1'b1, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 16'h00A2, 1'b0, 1'b0);
        step(1'b1, 16'h00A3, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("pushpop_pre_q_count", 32'(q_count), 32'd2);
        step(1'b1, 16'h00A4, 1'b0, 1'b0);
        chk("pushpop_q_count", 32'(q_count), 32'd2);
        chk("pushpop_data", 32'(data), 32'h00A2);

        // Queue full and wrap-around: spend all credits, fill, then stream 20 flits.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0F00 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("wrap_zero_credits", 32'(credit_cnt), 32'd0);
        pushed = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0100 + 16'(pushed), 1'b0, 1'b0);
            if (macc) pushed++;
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_q_count", 32'(q_count), 32'd4);
        chk("full_no_send", 32'(enable), 32'd0);
        given  = 0;
        pulses = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            v = (pushed < 20);
            c = (given < 20);
            step(v, 16'h0100 + 16'(pushed), c, 1'b0);
            if (macc) pushed++;
            if (c) given++;
            done = (pushed == 20) && (given == 20) && (mq.size() == 0) && !men;
        end
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_pulses", 32'(pulses), 32'd20);
        chk("wrap_last_data", 32'(data), 32'h0113);

        // Credit overflow with an empty queue and full credits.
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ovf_credit_cnt", 32'(credit_cnt), 32'd4);
        chk("ovf_err", 32'(credit_err), 32'(ErrEn));
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovf_err_sticky", 32'(credit_err), 32'(ErrEn));
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_err_cleared", 32'(credit_err), 32'd0);

        // Random traffic with a receiver that returns credits for consumed slots.
        for (int i = 0; i < 600; i++) begin
            outstanding = CREDITS - mcr;
            v = ($urandom_range(0, 99) < 60);
            c = ((outstanding > 0) && ($urandom_range(0, 99) < 50)) ||
                ($urandom_range(0, 99) == 0);
            step(v, 16'($urandom), c, ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
